// File: rtl/fetch_sequencer.sv
// Program counter and instruction register for the control unit: fetches words
// over a req/ready handshake, holds them until retired, and redirects on jump/branch.
module fetch_sequencer #(
  parameter int                 ADDR_W   = 12,
  parameter int                 INSTR_W  = 20,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               pcReadSignal,
  input  logic               isJump,
  input  logic               isBranch,
  input  logic [2:0]         nzp,
  input  logic [INSTR_W-1:0] jump_addr,
  input  logic [INSTR_W-1:0] immValue,
  input  logic               flag_update,
  input  logic [INSTR_W-1:0] alu_result,
  output logic [2:0]         flags,
  output logic [15:0]        retired_count
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  seq_pc;
  logic [ADDR_W-1:0]  next_pc;
  logic               taken;

  function automatic logic [2:0] flags_of(input logic [INSTR_W-1:0] v);
    logic n, z;
    n = v[INSTR_W-1];
    z = (v == '0);
    return {n, z, !n && !z};
  endfunction

  assign imem_addr = pc;

  // Branch decision uses the flags registered before this edge, so a
  // simultaneous flag_update only affects later branches.
  always_comb begin
    seq_pc  = instr_pc + ADDR_W'(1);
    taken   = isBranch && ((nzp & flags) != 3'b000);
    next_pc = seq_pc;
    if (isJump)
      next_pc = jump_addr[ADDR_W-1:0];
    else if (taken)
      next_pc = seq_pc + immValue[ADDR_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      instruction   <= '0;
      instr_pc      <= '0;
      instr_valid   <= 1'b0;
      imem_req      <= 1'b0;
      flags         <= 3'b010;
      retired_count <= 16'd0;
    end else begin
      if (flag_update)
        flags <= flags_of(alu_result);
      unique case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ready) begin
            instruction <= imem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (pcReadSignal) begin
            pc            <= next_pc;
            retired_count <= retired_count + 16'd1;
            instr_valid   <= 1'b0;
            imem_req      <= 1'b1;
            state         <= FETCH;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-supply side of the control unit. Owns the program counter, fetches 20-bit instructions from instruction memory over a request/ready handshake, and presents them in a held instruction register. It advances when the control unit asserts `pcReadSignal`, redirecting on jumps and on branches whose `nzp` mask matches the stored condition flags. The block sits between instruction memory and the control unit's `instruction` input, and is the consumer of the control unit's `pcReadSignal`, `isBranch`, `nzp`, `jump_addr` and `immValue` outputs.

## Interface
- `ADDR_W`, 12 — PC / instruction-memory address width; all PC arithmetic is mod 2^ADDR_W.
- `INSTR_W`, 20 — instruction and data word width.
- `RESET_PC`, 0 — PC value loaded on reset.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `imem_req`  out  1  — fetch request; high exactly in FETCH.
- `imem_addr`  out  ADDR_W  — equals `pc`.
- `imem_ready`  in  1  — memory has `imem_rdata` valid this cycle; only sampled in FETCH.
- `imem_rdata`  in  INSTR_W  — fetched word.
- `instruction`  out  INSTR_W  — instruction register (IR), drives control unit.
- `instr_valid`  out  1  — IR holds a fetched, not yet retired instruction (high in HOLD).
- `instr_pc`  out  ADDR_W  — address IR was fetched from.
- `pcReadSignal`  in  1  — retire the current instruction and advance; only sampled in HOLD.
- `isJump`  in  1  — current instruction is a jump.
- `isBranch`  in  1  — current instruction is a conditional branch.
- `nzp`  in  3  — branch condition mask {N,Z,P}.
- `jump_addr`  in  INSTR_W  — jump target; low ADDR_W bits used as an absolute address.
- `immValue`  in  INSTR_W  — sign-extended branch offset; low ADDR_W bits used.
- `flag_update`  in  1  — latch flags from `alu_result` this cycle.
- `alu_result`  in  INSTR_W  — value written back by ALU/load.
- `flags`  out  3  — stored {N,Z,P}.
- `retired_count`  out  16  — count of retired instructions, wraps.

## Operation
- States: IDLE, FETCH, HOLD.
- While `rst` is high: state is IDLE, `pc`=RESET_PC, `instruction`=0, `instr_pc`=0, `instr_valid`=0, `imem_req`=0, `flags`=3'b010, `retired_count`=0.
- IDLE → FETCH unconditionally, one cycle after reset is released.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. When `imem_ready`=1: IR←`imem_rdata`, `instr_pc`←`pc`, go to HOLD. Otherwise remain in FETCH with the same address. There is no timeout.
- HOLD: `instr_valid`=1 and IR is stable. When `pcReadSignal`=1: compute `pc` per the priority list below, increment `retired_count`, go to FETCH.
- Next-PC priority:
  1. If `isJump`: `jump_addr[ADDR_W-1:0]`.
  2. Else if `isBranch` and (`nzp` & `flags`) ≠ 0: `instr_pc` + 1 + `immValue[ADDR_W-1:0]`.
  3. Otherwise: `instr_pc` + 1.
- All PC sums wrap mod 2^ADDR_W; a 4095 + 1 sequential step gives 0.
- Flags: on `flag_update`, N=`alu_result[19]`, Z=(`alu_result`==0), P=!N&&!Z. Exactly one flag is ever set. Flag updates are accepted in any non-reset state.
- Simultaneous `flag_update` and branch retire: the branch decision uses the flags registered before this edge; the new flags take effect afterwards.
- `isJump`, `isBranch`, `nzp`, `jump_addr` and `immValue` are ignored unless retiring in HOLD.
- Reset asserted mid-fetch or mid-hold: all state returns to reset values at that edge, and any in-flight `imem_ready` is ignored.

## Timing
- All outputs are registered or decoded from registered state only; there is no combinational path from any input to any output.
- With `imem_ready` tied high, each instruction takes 2 cycles (FETCH, HOLD). Each ready-low cycle adds 1 cycle.
- `instruction` and `instr_valid` update on the edge that samples `imem_ready`=1.
- `imem_req` rises on the edge after `pcReadSignal` is sampled, and `imem_addr` shows the new PC in that same cycle.
- First `imem_req` after reset: 1 cycle after `rst` falls (IDLE), asserted in the second cycle.

## Test plan
- Reset then straight-line fetch, ready tied high, `pcReadSignal` pulsed in each HOLD: addresses 0,1,2,3 requested; `retired_count`=3 after three retires; `flags`=010 throughout.
- Memory wait: hold `imem_ready` low 3 cycles at address 5 → `imem_req` stays high with `imem_addr`=5 for 4 cycles; `instr_valid` stays low until the ready edge; IR equals the word presented in the ready cycle.
- Jump: `instr_pc`=10, `isJump`=1, `jump_addr`=20'h00123 → next `imem_addr`=12'h123. Same instruction with `isBranch`=1 also set → jump still wins.
- Branch taken/not taken: `flags`=100 (after `alu_result`=20'h80000), `nzp`=100, `immValue`=20'hFFFFC, `instr_pc`=8 → next PC 5. Repeat with `nzp`=011 → next PC 9.
- Wrap and hazard: `instr_pc`=4095, no redirect → next PC 0. In the same cycle, `flag_update` with `alu_result`=0 and a branch with `nzp`=010 while `flags`=001 → branch not taken; `flags`=010 afterwards.
- Mid-operation reset: assert `rst` during FETCH with `imem_ready`=1 → IR stays 0, `pc`=RESET_PC, `imem_req`=0, and fetch resumes from RESET_PC.
